// File: rtl/spike_window_classifier.sv
`timescale 1ns/1ps
// spike_window_classifier
// Counts output-neuron spikes per class over a programmable window of
// timesteps, runs a one-class-per-cycle argmax scan, and presents the winning
// class index, its count and a tie indication on a valid/ready handshake.
// Optional feature macro: CLASSIFIER_EARLY_EXIT_EN adds the early_thresh input;
// the window then also ends as soon as any class count reaches the threshold.
module spike_window_classifier #(
    parameter int N_OUTPUTS = 10,
    parameter int CNT_WIDTH = 16,
    parameter int T_WIDTH   = 10,
    localparam int IDX_WIDTH = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [T_WIDTH-1:0]   window_len,
`ifdef CLASSIFIER_EARLY_EXIT_EN
    input  logic [CNT_WIDTH-1:0] early_thresh,
`endif
    input  logic                 spike_valid,
    input  logic [N_OUTPUTS-1:0] spike_in,
    output logic                 busy,
    output logic                 class_valid,
    input  logic                 class_ready,
    output logic [IDX_WIDTH-1:0] class_id,
    output logic [CNT_WIDTH-1:0] class_count,
    output logic                 tie_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_OUTPUTS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Saturating increment: a full counter stays full instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    state_e               state_q, state_d;
    logic [T_WIDTH-1:0]   win_len_q, win_len_d;
    logic [T_WIDTH-1:0]   ts_cnt_q, ts_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q [N_OUTPUTS];
    logic [CNT_WIDTH-1:0] cnt_d [N_OUTPUTS];
    logic [IDX_WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [CNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
    logic                 best_tie_q, best_tie_d;
    logic                 busy_q, busy_d;
    logic                 class_valid_q, class_valid_d;
    logic [IDX_WIDTH-1:0] class_id_q, class_id_d;
    logic [CNT_WIDTH-1:0] class_count_q, class_count_d;
    logic                 tie_flag_q, tie_flag_d;
`ifdef CLASSIFIER_EARLY_EXIT_EN
    logic [CNT_WIDTH-1:0] thresh_q, thresh_d;
`endif

    logic [CNT_WIDTH-1:0] scan_cnt;
    logic                 early_hit;

    // Select the counter addressed by the scan index (explicit mux keeps the
    // index range within the counter array).
    always_comb begin
        scan_cnt = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            if (scan_idx_q == IDX_WIDTH'(i)) begin
                scan_cnt = cnt_q[i];
            end else begin
                scan_cnt = scan_cnt;
            end
        end
    end

    // Next-state and datapath computation for the whole classifier.
    always_comb begin
        state_d       = state_q;
        win_len_d     = win_len_q;
        ts_cnt_d      = ts_cnt_q;
        cnt_d         = cnt_q;
        scan_idx_d    = scan_idx_q;
        best_idx_d    = best_idx_q;
        best_cnt_d    = best_cnt_q;
        best_tie_d    = best_tie_q;
        class_valid_d = class_valid_q;
        class_id_d    = class_id_q;
        class_count_d = class_count_q;
        tie_flag_d    = tie_flag_q;
        early_hit     = 1'b0;
`ifdef CLASSIFIER_EARLY_EXIT_EN
        thresh_d      = thresh_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_len_d  = window_len;
                    ts_cnt_d   = '0;
                    scan_idx_d = '0;
                    for (int i = 0; i < N_OUTPUTS; i++) begin
                        cnt_d[i] = '0;
                    end
`ifdef CLASSIFIER_EARLY_EXIT_EN
                    thresh_d = early_thresh;
`endif
                    // A zero-length window has nothing to count: scan the cleared counters.
                    if (window_len == '0) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COUNT: begin
                if (spike_valid) begin
                    for (int i = 0; i < N_OUTPUTS; i++) begin
                        if (spike_in[i]) begin
                            cnt_d[i] = sat_inc(cnt_q[i]);
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                    ts_cnt_d = ts_cnt_q + T_WIDTH'(1);
`ifdef CLASSIFIER_EARLY_EXIT_EN
                    // Threshold is checked against the counts including this beat.
                    if (thresh_q != '0) begin
                        for (int i = 0; i < N_OUTPUTS; i++) begin
                            if (cnt_d[i] >= thresh_q) begin
                                early_hit = 1'b1;
                            end else begin
                                early_hit = early_hit;
                            end
                        end
                    end else begin
                        early_hit = 1'b0;
                    end
`endif
                    if ((ts_cnt_d == win_len_q) || early_hit) begin
                        state_d    = ST_SCAN;
                        scan_idx_d = '0;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else begin
                    state_d = ST_COUNT;
                end
            end

            ST_SCAN: begin
                // Index 0 seeds the best; only a strictly larger count replaces
                // it, so the lowest index wins ties.
                if (scan_idx_q == '0) begin
                    best_idx_d = '0;
                    best_cnt_d = scan_cnt;
                    best_tie_d = 1'b0;
                end else if (scan_cnt > best_cnt_q) begin
                    best_idx_d = scan_idx_q;
                    best_cnt_d = scan_cnt;
                    best_tie_d = 1'b0;
                end else if (scan_cnt == best_cnt_q) begin
                    best_tie_d = 1'b1;
                end else begin
                    best_tie_d = best_tie_q;
                end

                if (scan_idx_q == LAST_IDX) begin
                    state_d    = ST_OUT;
                    scan_idx_d = '0;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
                end
            end

            ST_OUT: begin
                // First OUT cycle publishes the scan result; it then holds
                // until the consumer takes it.
                if (!class_valid_q) begin
                    class_valid_d = 1'b1;
                    class_id_d    = best_idx_q;
                    class_count_d = best_cnt_q;
                    tie_flag_d    = best_tie_q;
                end else if (class_ready) begin
                    class_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    class_valid_d = 1'b1;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                class_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            win_len_q     <= '0;
            ts_cnt_q      <= '0;
            for (int i = 0; i < N_OUTPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            scan_idx_q    <= '0;
            best_idx_q    <= '0;
            best_cnt_q    <= '0;
            best_tie_q    <= 1'b0;
            busy_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_id_q    <= '0;
            class_count_q <= '0;
            tie_flag_q    <= 1'b0;
`ifdef CLASSIFIER_EARLY_EXIT_EN
            thresh_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            win_len_q     <= win_len_d;
            ts_cnt_q      <= ts_cnt_d;
            for (int i = 0; i < N_OUTPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            scan_idx_q    <= scan_idx_d;
            best_idx_q    <= best_idx_d;
            best_cnt_q    <= best_cnt_d;
            best_tie_q    <= best_tie_d;
            busy_q        <= busy_d;
            class_valid_q <= class_valid_d;
            class_id_q    <= class_id_d;
            class_count_q <= class_count_d;
            tie_flag_q    <= tie_flag_d;
`ifdef CLASSIFIER_EARLY_EXIT_EN
            thresh_q      <= thresh_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign class_valid = class_valid_q;
    assign class_id    = class_id_q;
    assign class_count = class_count_q;
    assign tie_flag    = tie_flag_q;

endmodule

// File: tb/tb_spike_window_classifier.sv
`timescale 1ns/1ps
// Bench for spike_window_classifier: windows of spikes are driven cycle by
// cycle and results are compared with a per-class counting/argmax model.
module tb_spike_window_classifier;
    localparam int N    = 10;
    localparam int CW   = 4;
    localparam int TW   = 10;
    localparam int IW   = 4;
    localparam int CMAX = 15;
`ifdef CLASSIFIER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [TW-1:0] window_len;
    logic          spike_valid;
    logic [N-1:0]  spike_in;
    logic          class_ready;
    logic          busy;
    logic          class_valid;
    logic [IW-1:0] class_id;
    logic [CW-1:0] class_count;
    logic          tie_flag;
`ifdef CLASSIFIER_EARLY_EXIT_EN
    logic [CW-1:0] early_thresh;
`endif

    int errors = 0;
    int checks = 0;
    int exp_id;
    int exp_cnt;
    bit exp_tie;
    logic [N-1:0] pat_q[$];

    spike_window_classifier #(.N_OUTPUTS(N), .CNT_WIDTH(CW), .T_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
`ifdef CLASSIFIER_EARLY_EXIT_EN
        .early_thresh(early_thresh),
`endif
        .spike_valid(spike_valid), .spike_in(spike_in), .busy(busy),
        .class_valid(class_valid), .class_ready(class_ready), .class_id(class_id),
        .class_count(class_count), .tie_flag(tie_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one window from pat_q, models it, and checks latency and result.
    // Leaves the DUT in OUT with class_ready low.
    task automatic run_window(input int len, input int thr, input bit gaps, input bit noise);
        int cnt[N];
        int beats = 0;
        int pidx = 0;
        int lat = 0;
        int mx = 0;
        int occ = 0;
        bit done;
        bit phase = 1'b0;
        bit hit;
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        class_ready = 1'b0;
        window_len = TW'(len);
`ifdef CLASSIFIER_EARLY_EXIT_EN
        early_thresh = CW'(thr);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        done = (len == 0);
        while (!done) begin
            if (gaps && phase) begin
                spike_valid = 1'b0;
                spike_in = N'($urandom);
            end else begin
                spike_valid = 1'b1;
                b = (pidx < pat_q.size()) ? pat_q[pidx] : N'($urandom);
                spike_in = b;
            end
            if (noise) begin
                start = 1'($urandom);
                window_len = TW'($urandom);
            end
            tick();
            if (spike_valid) begin
                for (int i = 0; i < N; i++)
                    if (spike_in[i]) cnt[i] = (cnt[i] < CMAX) ? cnt[i] + 1 : CMAX;
                beats++;
                pidx++;
                hit = 1'b0;
                for (int i = 0; i < N; i++) if (thr != 0 && cnt[i] >= thr) hit = 1'b1;
                done = (beats == len) || (EARLY && hit);
            end
            phase = ~phase;
        end
        spike_valid = 1'b0;
        start = 1'b0;
        spike_in = N'($urandom);
        // Expected result: highest count, lowest index holding it, tie if shared.
        for (int i = 0; i < N; i++) if (cnt[i] > mx) mx = cnt[i];
        exp_id = -1;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] == mx) begin
                occ++;
                if (exp_id < 0) exp_id = i;
            end
        end
        exp_cnt = mx;
        exp_tie = (occ > 1);
        while (class_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != N + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles want %0d", lat, N + 1);
        end
        checks++;
        if (class_id !== IW'(exp_id)) begin
            errors++;
            $display("FAIL class_id: got %0d want %0d", class_id, exp_id);
        end
        checks++;
        if (class_count !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL class_count: got %0d want %0d", class_count, exp_cnt);
        end
        checks++;
        if (tie_flag !== exp_tie) begin
            errors++;
            $display("FAIL tie_flag: got %b want %b", tie_flag, exp_tie);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_out: got %b want 1", busy);
        end
    endtask

    // Accept the result and confirm return to IDLE with the result retained.
    task automatic do_handshake();
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle: valid=%b busy=%b want 0 0", class_valid, busy);
        end
        checks++;
        if (class_id !== IW'(exp_id) || class_count !== CW'(exp_cnt) || tie_flag !== exp_tie) begin
            errors++;
            $display("FAIL idle_hold: id=%0d cnt=%0d tie=%b want %0d %0d %b",
                     class_id, class_count, tie_flag, exp_id, exp_cnt, exp_tie);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; window_len = '0; spike_valid = 1'b0;
        spike_in = '0; class_ready = 1'b0;
`ifdef CLASSIFIER_EARLY_EXIT_EN
        early_thresh = '0;
`endif
        #12;
        checks++;
        if (busy !== 1'b0 || class_valid !== 1'b0 || class_id !== '0 ||
            class_count !== '0 || tie_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b id=%0d cnt=%0d tie=%b want all 0",
                     busy, class_valid, class_id, class_count, tie_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pat_q = {10'h088, 10'h088, 10'h008, 10'h008};
        run_window(4, 0, 1'b0, 1'b0);
        do_handshake();
    endtask

    task automatic test_tie();
        pat_q = {10'h024, 10'h024, 10'h024};
        run_window(3, 0, 1'b0, 1'b0);
        do_handshake();
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 12);
            pat_q.delete();
            for (int j = 0; j < len; j++) pat_q.push_back(N'($urandom) & N'($urandom));
            run_window(len, 0, 1'($urandom), 1'b1);
            do_handshake();
        end
    endtask

    task automatic test_backpressure();
        pat_q = {10'h200, 10'h201, 10'h001};
        run_window(3, 0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            window_len = TW'(3);
            tick();
            checks++;
            if (class_valid !== 1'b1 || class_id !== IW'(exp_id) ||
                class_count !== CW'(exp_cnt) || tie_flag !== exp_tie) begin
                errors++;
                $display("FAIL backpressure_hold: valid=%b id=%0d cnt=%0d tie=%b want 1 %0d %0d %b",
                         class_valid, class_id, class_count, tie_flag, exp_id, exp_cnt, exp_tie);
            end
        end
        start = 1'b0;
        do_handshake();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: busy=%b want 0", busy);
        end
    endtask

    task automatic test_saturation();
        pat_q.delete();
        for (int j = 0; j < 20; j++) pat_q.push_back(10'h001);
        run_window(20, 0, 1'b1, 1'b0);
        do_handshake();
    endtask

    task automatic test_zero_window();
        pat_q.delete();
        run_window(0, 0, 1'b0, 1'b0);
        do_handshake();
    endtask

    task automatic test_async_reset();
        test_basic();
        window_len = TW'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            spike_valid = 1'b1;
            spike_in = 10'h3FF;
            tick();
        end
        spike_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || class_valid !== 1'b0 || class_id !== '0 ||
            class_count !== '0 || tie_flag !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b id=%0d cnt=%0d tie=%b want all 0",
                     busy, class_valid, class_id, class_count, tie_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_basic();
    endtask

`ifdef CLASSIFIER_EARLY_EXIT_EN
    task automatic test_early_exit();
        pat_q.delete();
        for (int j = 0; j < 100; j++) pat_q.push_back(10'h100);
        run_window(100, 5, 1'b0, 1'b0);
        do_handshake();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_random();
        test_backpressure();
        test_saturation();
        test_zero_window();
        test_async_reset();
`ifdef CLASSIFIER_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
Downstream stage of the output spike accumulators in the Neuro-Edge inference pipeline. It counts output-neuron spikes over a programmable window of timesteps, then runs a sequential argmax scan. The result is presented as a predicted class index on a valid/ready handshake to the host or readout interface.

Parameters:
N_OUTPUTS, 10, number of output neurons/classes
CNT_WIDTH, 16, width of each per-class spike counter (saturating)
T_WIDTH, 10, width of window length (timesteps per inference)
IDX_WIDTH, $clog2(N_OUTPUTS), width of class index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins an inference window (honoured only in IDLE)
window_len  input  T_WIDTH  timesteps per window; sampled on accepted start
spike_valid  input  1  one timestep of output spikes present on spike_in
spike_in  input  N_OUTPUTS  output spike vector for the current timestep
busy  output  1  high in any state other than IDLE
class_valid  output  1  result available
class_ready  input  1  consumer accepts result
class_id  output  IDX_WIDTH  winning class index
class_count  output  CNT_WIDTH  spike count of winning class
tie_flag  output  1  another class equalled the winning count

Behaviour:
- Reset (async, any state): state=IDLE, all counters/timestep count/scan index cleared; busy=0, class_valid=0, class_id=0, class_count=0, tie_flag=0.
- States: IDLE, COUNT, SCAN, OUT.
- IDLE: start=1 -> latch window_len, clear all class counters and timestep counter. If window_len!=0 -> COUNT. If window_len==0 -> SCAN directly (all counts 0).
- COUNT: each cycle with spike_valid=1 is one timestep. For each i with spike_in[i]=1, counter[i]+=1, saturating at 2^CNT_WIDTH-1 (no wrap). Timestep counter increments. On the beat that is timestep number window_len -> SCAN next cycle. spike_valid=0 cycles are idle; no timeout.
- SCAN: one class per cycle, index 0..N_OUTPUTS-1, N_OUTPUTS cycles total. Index 0 seeds best. Later index replaces best only if its count is strictly greater; this clears tie_flag. Equal count sets tie_flag. Lowest index wins ties. After the last index -> OUT.
- OUT: class_valid=1 and class_id/class_count/tie_flag held stable until class_valid&&class_ready. Handshake cycle -> IDLE and class_valid=0 next cycle. class_id/class_count/tie_flag keep their last values in IDLE.
- Latency: last accepted spike beat at edge k -> class_valid high after edge k+1+N_OUTPUTS. With class_ready held high, busy drops at edge k+2+N_OUTPUTS.
- Ignored inputs: start outside IDLE (no restart, no error); spike_valid/spike_in outside COUNT.
- start and last spike beat can never coincide, since they are valid in different states.

Optional Feature:
CLASSIFIER_EARLY_EXIT_EN:
- Defined: adds input early_thresh (CNT_WIDTH), sampled with start. In COUNT, if early_thresh!=0 and any counter reaches >= early_thresh after the current beat's update, go to SCAN next cycle even if fewer than window_len timesteps have elapsed. Window-end exit still applies.
- Undefined: port absent; window always runs the full window_len timesteps.

Test Plan:
- Basic argmax: N=10, window_len=4, spike_in bit 3 set on all 4 beats, bit 7 on 2 beats -> class_id=3, class_count=4, tie_flag=0. class_valid rises 11 cycles after the 4th beat.
- Tie: window_len=3, bits 2 and 5 set on all beats -> class_id=2, class_count=3, tie_flag=1.
- Backpressure/ignored start: class_ready=0 for 20 cycles with start pulsed during OUT -> outputs stable, class_valid held, no new window. class_ready=1 -> IDLE, busy=0 next cycle.
- Saturation and gaps: CNT_WIDTH=4, window_len=20, bit 0 set every beat, spike_valid toggling 1/0 -> class_count=15, completes after the 20th valid beat.
- Zero window and async reset: window_len=0 -> class_id=0, class_count=0, tie_flag=1. Assert rst_n=0 mid-COUNT -> all outputs 0 immediately, and the next start runs cleanly.
- Early exit (macro defined): early_thresh=5, window_len=100, bit 8 set every beat -> SCAN after 5th beat, class_id=8, class_count=5.
